// File: rtl/txshift.sv
// txshift: serial transmit shift register for the USRT link.
//
// Takes bytes over a valid/ready handshake and sends each one on o_Tx_Serial
// as an 11-bit frame: start (0), 8 data bits LSB first, bit 9, stop (1).
// i_Bclk is a level sampled in the i_Pclk domain. The line only moves on a
// detected rising edge of that level, so the far end can sample on falling
// edges.
//
// A one-entry holding register sits in front of the shifter. The next byte
// can be queued while a frame is on the line, and it follows with no idle bit.
//
// Build option: define TXSHIFT_PARITY_EN to carry a parity bit in bit 9.
// PARITY_ODD selects even (0) or odd (1) parity. With the macro undefined,
// bit 9 is a second stop bit and PARITY_ODD has no effect.

module txshift #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic       i_Bclk,
    input  logic       i_Tx_Start,
    input  logic [7:0] i_Tx_Data,
    output logic       o_Tx_Serial,
    output logic       o_Ready,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int          FRAME_BITS = 11;
    localparam logic [3:0]  LAST_IDX   = 4'd10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_reg, state_next;

    logic                    bclk_prev_reg;
    logic                    bclk_rise;

    logic                    hold_full_reg, hold_full_next;
    logic [7:0]              hold_data_reg, hold_data_next;

    logic [FRAME_BITS-1:0]   frame_reg, frame_next;
    logic [3:0]              idx_reg, idx_next;
    logic [3:0]              idx_inc;

    logic                    tx_reg, tx_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    logic                    parity_bit;
    logic [FRAME_BITS-1:0]   hold_frame;

    // Bit-clock rising edge: this cycle's level is high and last cycle's was low.
    assign bclk_rise = i_Bclk & ~bclk_prev_reg;
    assign idx_inc   = idx_reg + 4'd1;

`ifdef TXSHIFT_PARITY_EN
    // Parity over the queued byte. Odd parity inverts the XOR reduction.
    assign parity_bit = PARITY_ODD ? ~(^hold_data_reg) : (^hold_data_reg);
`else
    // Second stop bit. The parameter is folded in only to keep it referenced;
    // the result is always 1.
    assign parity_bit = 1'b1 | PARITY_ODD;
`endif

    // Frame image of the queued byte: start, data LSB first, bit 9, stop.
    assign hold_frame[0]            = 1'b0;
    assign hold_frame[9]            = parity_bit;
    assign hold_frame[FRAME_BITS-1] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_frame_data
            assign hold_frame[gi+1] = hold_data_reg[gi];
        end
    endgenerate

    // Next-state, handshake and line logic. All updates are gated by a
    // bit-clock rise, except the byte load, which follows the handshake.
    always_comb begin
        state_next     = state_reg;
        hold_full_next = hold_full_reg;
        hold_data_next = hold_data_reg;
        frame_next     = frame_reg;
        idx_next       = idx_reg;
        tx_next        = tx_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        // Accept a byte only while the holding register is empty. A transfer
        // needs the register full, so a load and a transfer never happen in
        // the same cycle.
        if (i_Tx_Start && !hold_full_reg) begin
            hold_full_next = 1'b1;
            hold_data_next = i_Tx_Data;
        end

        case (state_reg)
            ST_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (bclk_rise && hold_full_reg) begin
                    frame_next     = hold_frame;
                    idx_next       = 4'd0;
                    tx_next        = hold_frame[0];
                    busy_next      = 1'b1;
                    hold_full_next = 1'b0;
                    state_next     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bclk_rise) begin
                    if (idx_reg != LAST_IDX) begin
                        idx_next = idx_inc;
                        tx_next  = frame_reg[idx_inc];
                    end else begin
                        // The stop bit has been on the line for a full bit time.
                        done_next = 1'b1;
                        if (hold_full_reg) begin
                            // Back-to-back: the next start bit replaces the stop bit.
                            frame_next     = hold_frame;
                            idx_next       = 4'd0;
                            tx_next        = hold_frame[0];
                            hold_full_next = 1'b0;
                        end else begin
                            idx_next   = 4'd0;
                            tx_next    = 1'b1;
                            busy_next  = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any frame in flight and
    // clears the holding register.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_reg     <= ST_IDLE;
            bclk_prev_reg <= 1'b0;
            hold_full_reg <= 1'b0;
            hold_data_reg <= 8'h00;
            frame_reg     <= '1;
            idx_reg       <= 4'd0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bclk_prev_reg <= i_Bclk;
            hold_full_reg <= hold_full_next;
            hold_data_reg <= hold_data_next;
            frame_reg     <= frame_next;
            idx_reg       <= idx_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign o_Tx_Serial = tx_reg;
    assign o_Ready     = ~hold_full_reg;
    assign o_Busy      = busy_reg;
    assign o_Done      = done_reg;

endmodule
